word_rotator_seq: RTL and testbench
===================================

// Module: word_rotator_seq
// PURPOSE
//   Sequential, parametrised cyclic byte rotator for key-schedule words.
//   Rotates a WORD_BYTES*BYTE-bit word left or right by a run-time byte count,
//   one byte position per clock, behind valid/ready handshakes on both sides.
//   Sits between the key-word register file and the SubWord/Rcon stage;
//   in_amount=1, in_dir=0 gives the AES RotWord result.
// PARAMETERS
//   BYTE        8   bits per byte (rotation granule)
//   WORD_BYTES  4   bytes per word; word width WORD = BYTE*WORD_BYTES
//   AMT_W       3   width of in_amount; amounts up to 2^AMT_W-1 accepted
// PORTS
//   clk        in   1        single clock, all state on rising edge
//   reset      in   1        synchronous, active-high
//   in_valid   in   1        request present
//   in_ready   out  1        block can accept a request
//   in_word    in   WORD     word to rotate
//   in_amount  in   AMT_W    byte positions to rotate
//   in_dir     in   1        0 = left (MSB byte wraps to LSB), 1 = right
//   out_valid  out  1        result available
//   out_ready  in   1        consumer takes result
//   out_word   out  WORD     rotated word
//   busy       out  1        high whenever state != IDLE
// BEHAVIOUR
//   Reset (sync, high): state=IDLE; in_ready=1; out_valid=0; out_word=0;
//     busy=0; internal word/count/dir regs cleared. Overrides any activity.
//   FSM states: IDLE, ROTATE, HOLD.
//   IDLE: in_ready=1. Accept edge = rising edge with in_valid&&in_ready.
//     Capture in_word, in_amount (cnt), in_dir.
//     cnt==0 -> HOLD (result = in_word unchanged); else -> ROTATE.
//   ROTATE: in_ready=0, out_valid=0. Each edge: rotate held word one byte in
//     captured dir; cnt<=cnt-1; when cnt reaches 0 on that edge -> HOLD.
//   HOLD: out_valid=1, out_word=held result, stable while out_ready=0.
//     Edge with out_ready=1 -> IDLE. in_ready stays 0 in HOLD (no overlap);
//     next request can be accepted at earliest the edge after the handoff.
//   Latency: out_valid rises after the k-th edge following the accept edge,
//     k=in_amount (k=0: out_valid visible right after the accept edge).
//   Amounts >= WORD_BYTES: no reduction; result equals rotation by
//     in_amount mod WORD_BYTES, latency remains in_amount cycles.
//   Left rotate by 1: {w[WORD-BYTE-1:0], w[WORD-1:WORD-BYTE]};
//     right rotate by 1: {w[BYTE-1:0], w[WORD-1:BYTE]}.
//   Inputs ignored outside IDLE; in_word/in_amount changes after accept
//     have no effect on the in-flight result.
//   out_word outside HOLD: holds last result (0 after reset); only
//     meaningful when out_valid=1.
//   Reset mid-ROTATE or mid-HOLD: result discarded, no out_valid pulse,
//     IDLE on the next cycle.
// TESTING
//   1. in_word=0x09CF4F3C, amt=1, dir=0 -> out_word=0xCF4F3C09, out_valid
//      after 1 edge past accept.
//   2. in_word=0x09CF4F3C, amt=1, dir=1 -> 0x3C09CF4F; amt=2, dir=0 ->
//      0x4F3C09CF after 2 edges; busy high throughout.
//   3. amt=0, in_word=0xDEADBEEF -> out_valid right after accept edge,
//      out_word=0xDEADBEEF.
//   4. amt=5, dir=0, in_word=0x11223344 -> 0x22334411 after 5 edges
//      (same as amt=1).
//   5. HOLD with out_ready low 3 cycles -> out_word/out_valid stable,
//      in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE, in_ready=1.
//   6. reset asserted during ROTATE (amt=3, after 1 edge) -> next cycle
//      IDLE, out_valid=0, out_word=0, busy=0; new request then completes.

Source files
------------

// File: rtl/word_rotator_seq.sv
// Sequential cyclic byte rotator for key-schedule words.
// A captured word is rotated one byte position per clock, in the captured
// direction, until the captured byte count runs out. The result is then held
// on the output until the consumer takes it.
module word_rotator_seq #(
  parameter int BYTE       = 8,
  parameter int WORD_BYTES = 4,
  parameter int AMT_W      = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BYTE*WORD_BYTES-1:0] in_word,
  input  logic [AMT_W-1:0]           in_amount,
  input  logic                       in_dir,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BYTE*WORD_BYTES-1:0] out_word,
  output logic                       busy
);

  localparam int WORD = BYTE * WORD_BYTES;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WORD-1:0]   word_q, word_d;
  logic [WORD-1:0]   res_q, res_d;
  logic [AMT_W-1:0]  cnt_q, cnt_d;
  logic              dir_q, dir_d;

  // One byte position of cyclic rotation; dir 0 moves the MSB byte to the LSB.
  function automatic logic [WORD-1:0] rot1(input logic [WORD-1:0] w, input logic dir);
    if (dir) rot1 = {w[BYTE-1:0], w[WORD-1:BYTE]};
    else     rot1 = {w[WORD-BYTE-1:0], w[WORD-1:WORD-BYTE]};
  endfunction

  // State and datapath registers; reset clears everything, including the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_d = in_word;
          cnt_d  = in_amount;
          dir_d  = in_dir;
          if (in_amount == '0) begin
            // Zero rotation: the captured word is already the result.
            res_d   = in_word;
            state_d = HOLD;
          end else begin
            state_d = ROTATE;
          end
        end
      end
      ROTATE: begin
        word_d = rot1(word_q, dir_q);
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          // Last step: publish the result only now so out_word never shows
          // partially rotated words.
          res_d   = rot1(word_q, dir_q);
          state_d = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_word = res_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_word_rotator_seq.sv
// Directed self-checking bench for word_rotator_seq.
module tb_word_rotator_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic [2:0]  in_amount;
  logic        in_dir;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        busy;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  word_rotator_seq #(.BYTE(8), .WORD_BYTES(4), .AMT_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_amount (in_amount),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Present a request for the accept edge, then scramble the inputs so any
  // late sampling would corrupt the result.
  task automatic send(input logic [31:0] w, input logic [2:0] a, input logic d);
    in_word   = w;
    in_amount = a;
    in_dir    = d;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_word   = 32'hFFFF_0000;
    in_amount = 3'd7;
    in_dir    = ~d;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_cnt++;
    if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL reset_flags got=%b want=100", {in_ready, out_valid, busy});
    else pass_cnt++;
    chk_cnt++;
    if (out_word !== 32'h0) $display("FAIL reset_word got=%h want=00000000", out_word);
    else pass_cnt++;
  endtask

  task automatic test_rotword();
    send(32'h09CF4F3C, 3'd1, 1'b0);
    chk_cnt++;
    if ({out_valid, busy, in_ready} !== 3'b010) $display("FAIL rotword_wait got=%b want=010", {out_valid, busy, in_ready});
    else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if (out_valid !== 1'b1 || out_word !== 32'hCF4F3C09) $display("FAIL rotword_res got=%b/%h want=1/cf4f3c09", out_valid, out_word);
    else pass_cnt++;
    take_result();
    chk_cnt++;
    if ({in_ready, busy, out_valid} !== 3'b100) $display("FAIL rotword_idle got=%b want=100", {in_ready, busy, out_valid});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    send(32'h09CF4F3C, 3'd1, 1'b1);
    @(posedge clk); #1;
    chk_cnt++;
    if (out_valid !== 1'b1 || out_word !== 32'h3C09CF4F) $display("FAIL right1 got=%b/%h want=1/3c09cf4f", out_valid, out_word);
    else pass_cnt++;
    take_result();
    send(32'h09CF4F3C, 3'd2, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk_cnt++;
      if ({out_valid, busy} !== 2'b01) $display("FAIL left2_wait%0d got=%b want=01", i, {out_valid, busy});
      else pass_cnt++;
      @(posedge clk); #1;
    end
    chk_cnt++;
    if ({out_valid, busy} !== 2'b11 || out_word !== 32'h4F3C09CF) $display("FAIL left2_res got=%b/%h want=11/4f3c09cf", {out_valid, busy}, out_word);
    else pass_cnt++;
    take_result();
  endtask

  task automatic test_zero();
    send(32'hDEADBEEF, 3'd0, 1'b0);
    chk_cnt++;
    if (out_valid !== 1'b1 || out_word !== 32'hDEADBEEF) $display("FAIL zero_amt got=%b/%h want=1/deadbeef", out_valid, out_word);
    else pass_cnt++;
    take_result();
    chk_cnt++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL zero_idle got=%b want=10", {in_ready, out_valid});
    else pass_cnt++;
  endtask

  task automatic test_wrap_amount();
    send(32'h11223344, 3'd5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk_cnt++;
      if (out_valid !== 1'b0) $display("FAIL amt5_wait%0d got=%b want=0", i, out_valid);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    chk_cnt++;
    if (out_valid !== 1'b1 || out_word !== 32'h22334411) $display("FAIL amt5_res got=%b/%h want=1/22334411", out_valid, out_word);
    else pass_cnt++;
    take_result();
  endtask

  task automatic test_hold_stall();
    send(32'hA1B2C3D4, 3'd1, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      in_valid  = i[0] ? 1'b0 : 1'b1;
      in_word   = 32'h5555AAAA;
      in_amount = 3'd0;
      chk_cnt++;
      if ({out_valid, in_ready} !== 2'b10 || out_word !== 32'hD4A1B2C3) $display("FAIL stall%0d got=%b/%h want=10/d4a1b2c3", i, {out_valid, in_ready}, out_word);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk_cnt++;
    if (out_valid !== 1'b1 || out_word !== 32'hD4A1B2C3) $display("FAIL stall_end got=%b/%h want=1/d4a1b2c3", out_valid, out_word);
    else pass_cnt++;
    take_result();
    chk_cnt++;
    if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL stall_release got=%b want=100", {in_ready, out_valid, busy});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    send(32'h11223344, 3'd3, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_cnt++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_word !== 32'h0) $display("FAIL midreset got=%b/%h want=100/00000000", {in_ready, out_valid, busy}, out_word);
    else pass_cnt++;
    send(32'h11223344, 3'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk_cnt++;
      if (out_valid !== 1'b0) $display("FAIL post_reset_wait%0d got=%b want=0", i, out_valid);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    chk_cnt++;
    if (out_valid !== 1'b1 || out_word !== 32'h44112233) $display("FAIL post_reset_res got=%b/%h want=1/44112233", out_valid, out_word);
    else pass_cnt++;
    take_result();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    in_amount = '0;
    in_dir    = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_rotword();
    test_back_to_back();
    test_zero();
    test_wrap_amount();
    test_hold_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
